// File: rtl/vproc_burst_master.sv
// rtl/vproc_burst_master.sv - command-driven burst bus master with tick delay and sticky interrupt latch
// Optional build macro: VPROC_TIMEOUT_EN (adds a per-beat ack timeout that ends the burst with RspErr=1)
module vproc_burst_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4,
   parameter int NUM_INT    = 3,
   parameter int TIMEOUT    = 256
) (
   input  logic                  Clk,
   input  logic                  nReset,
   // command channel
   input  logic                  CmdValid,
   output logic                  CmdReady,
   input  logic [1:0]            CmdOp,
   input  logic [ADDR_WIDTH-1:0] CmdAddr,
   input  logic [DATA_WIDTH-1:0] CmdData,
   input  logic [LEN_WIDTH-1:0]  CmdLen,
   input  logic [31:0]           CmdTicks,
   // write data supply
   input  logic [DATA_WIDTH-1:0] WData,
   output logic                  WDataReq,
   // responses
   output logic                  RspValid,
   output logic [DATA_WIDTH-1:0] RspData,
   output logic                  RspLast,
   output logic                  RspErr,
   // bus
   output logic [ADDR_WIDTH-1:0] Addr,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic                  WE,
   output logic                  RD,
   input  logic [DATA_WIDTH-1:0] DataIn,
   input  logic                  WRAck,
   input  logic                  RDAck,
   // interrupts
   input  logic [NUM_INT-1:0]    Interrupt,
   output logic [NUM_INT-1:0]    IntPending,
   input  logic [NUM_INT-1:0]    IntClear
);

   typedef enum logic [2:0] {S_IDLE, S_TICK, S_WRITE, S_READ, S_RESP} state_t;

   // one beat advances the address by the bus width in bytes; wrap comes free from the adder width
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

`ifdef VPROC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);
   logic [TW-1:0] r_tmo;
`endif

   state_t                r_state;
   logic                  r_cmd_ready;
   logic [LEN_WIDTH-1:0]  r_left;
   logic [31:0]           r_ticks;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_we;
   logic                  r_rd;
   logic                  r_wdata_req;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_rsp_last;
   logic                  r_rsp_err;
   logic [NUM_INT-1:0]    r_int_d;
   logic [NUM_INT-1:0]    r_int_pend;
   logic [NUM_INT-1:0]    w_int_rise;

   assign CmdReady   = r_cmd_ready;
   assign WDataReq   = r_wdata_req;
   assign RspValid   = r_rsp_valid;
   assign RspData    = r_rsp_data;
   assign RspLast    = r_rsp_last;
   assign RspErr     = r_rsp_err;
   assign Addr       = r_addr;
   assign DataOut    = r_data_out;
   assign WE         = r_we;
   assign RD         = r_rd;
   assign IntPending = r_int_pend;
   assign w_int_rise = Interrupt & ~r_int_d;

   // Transaction FSM: every completion (tick end, last ack, illegal op, timeout) parks one cycle in RESP
   // with the response pulse, which also guarantees an idle gap before the next command.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_left      <= '0;
         r_ticks     <= '0;
         r_addr      <= '0;
         r_data_out  <= '0;
         r_we        <= 1'b0;
         r_rd        <= 1'b0;
         r_wdata_req <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_last  <= 1'b0;
         r_rsp_err   <= 1'b0;
`ifdef VPROC_TIMEOUT_EN
         r_tmo       <= '0;
`endif
      end else begin
         r_wdata_req <= 1'b0;
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (CmdValid) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= CmdAddr;
                  r_left      <= CmdLen;
                  r_rsp_last  <= 1'b0;
                  r_rsp_err   <= 1'b0;
`ifdef VPROC_TIMEOUT_EN
                  r_tmo       <= '0;
`endif
                  case (CmdOp)
                     2'b00: begin
                        // a zero delay still costs one cycle so the response never overlaps acceptance
                        r_ticks <= (CmdTicks == 32'd0) ? 32'd1 : CmdTicks;
                        r_state <= S_TICK;
                     end
                     2'b01: begin
                        r_data_out <= CmdData;
                        r_we       <= 1'b1;
                        r_state    <= S_WRITE;
                     end
                     2'b10: begin
                        r_rd    <= 1'b1;
                        r_state <= S_READ;
                     end
                     default: begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                     end
                  endcase
               end
            end
            S_TICK: begin
               if (r_ticks == 32'd1) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_last  <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_ticks <= r_ticks - 32'd1;
               end
            end
            S_WRITE: begin
               if (WRAck) begin
`ifdef VPROC_TIMEOUT_EN
                  r_tmo <= '0;
`endif
                  if (r_left != '0) begin
                     // next beat: WE stays high so the slave sees back-to-back writes
                     r_data_out  <= WData;
                     r_wdata_req <= 1'b1;
                     r_addr      <= r_addr + ADDR_STEP;
                     r_left      <= r_left - LEN_ONE;
                  end else begin
                     r_we        <= 1'b0;
                     r_rsp_valid <= 1'b1;
                     r_rsp_last  <= 1'b1;
                     r_rsp_err   <= 1'b0;
                     r_state     <= S_RESP;
                  end
               end
`ifdef VPROC_TIMEOUT_EN
               else if (r_tmo == TMO_LAST) begin
                  r_we        <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_last  <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_tmo <= r_tmo + TMO_ONE;
               end
`endif
            end
            S_READ: begin
               if (RDAck) begin
`ifdef VPROC_TIMEOUT_EN
                  r_tmo <= '0;
`endif
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= DataIn;
                  r_addr      <= r_addr + ADDR_STEP;
                  if (r_left == '0) begin
                     r_rsp_last <= 1'b1;
                     r_rd       <= 1'b0;
                     r_state    <= S_RESP;
                  end else begin
                     r_left <= r_left - LEN_ONE;
                  end
               end
`ifdef VPROC_TIMEOUT_EN
               else if (r_tmo == TMO_LAST) begin
                  r_rd        <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_last  <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_tmo <= r_tmo + TMO_ONE;
               end
`endif
            end
            S_RESP: begin
               r_rsp_last  <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_we        <= 1'b0;
               r_rd        <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky interrupt latch: a new rising edge wins over a clear in the same cycle
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_int_d    <= '0;
         r_int_pend <= '0;
      end else begin
         r_int_d    <= Interrupt;
         r_int_pend <= (r_int_pend & ~IntClear) | w_int_rise;
      end
   end

endmodule

// File: doc/vproc_burst_master.md
VPROC_BURST_MASTER -- requirements
Module: vproc_burst_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bus data width, multiple of 8.
REQ-003 SHALL have parameter LEN_WIDTH, default 4: burst length field width; beats = CmdLen+1.
REQ-004 SHALL have parameter NUM_INT, default 3: interrupt line count.
REQ-005 SHALL have parameter TIMEOUT, default 256: ack timeout in cycles.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: Clk  in  1  clock, rising edge; nReset  in  1  asynchronous active-low reset.
REQ-007 SHALL have these command ports: CmdValid  in  1  command offered; CmdReady  out  1  command accepted when both high; CmdOp  in  2  bit0 write, bit1 read, 00 tick-only, 11 illegal; CmdAddr  in  ADDR_WIDTH  start address; CmdData  in  DATA_WIDTH  first write beat; CmdLen  in  LEN_WIDTH  beats minus one; CmdTicks  in  32  tick-only delay.
REQ-008 SHALL have these write-data ports: WData  in  DATA_WIDTH  next write beat; WDataReq  out  1  one-cycle pulse when WData is consumed.
REQ-009 SHALL have these response ports: RspValid  out  1  one-cycle response pulse; RspData  out  DATA_WIDTH  read beat; RspLast  out  1  final beat or completion; RspErr  out  1  error.
REQ-010 SHALL have these bus ports: Addr  out  ADDR_WIDTH; DataOut  out  DATA_WIDTH; WE  out  1; RD  out  1; DataIn  in  DATA_WIDTH; WRAck  in  1; RDAck  in  1.
REQ-011 SHALL have these interrupt ports: Interrupt  in  NUM_INT  level inputs; IntPending  out  NUM_INT  sticky latched edges; IntClear  in  NUM_INT  write-1-to-clear mask.

Function
REQ-012 SHALL implement states IDLE, TICK, WRITE, READ, RESP; CmdReady high only in IDLE.
REQ-013 SHALL leave IDLE on acceptance at edge k; WE or RD SHALL be high from edge k+1; Op 00 -> TICK, 01 -> WRITE, 10 -> READ, 11 -> RESP with RspErr=1.
REQ-014 TICK SHALL pulse RspValid with RspLast=1 in the cycle after edge k+max(CmdTicks,1), then return to IDLE.
REQ-015 WRITE SHALL drive DataOut=CmdData on beat 0; on each sampled WRAck with beats remaining SHALL load DataOut from WData, pulse WDataReq, and advance Addr, keeping WE high back-to-back.
REQ-016 READ SHALL, on each sampled RDAck, pulse RspValid with RspData=DataIn, set RspLast on the final beat, and advance Addr.
REQ-017 Addr SHALL advance by DATA_WIDTH/8 per beat, wrapping modulo 2^ADDR_WIDTH.
REQ-018 On the final write ack, WE SHALL drop next cycle with one RspValid, RspLast=1, RspErr=0; on the final read ack, RD SHALL drop next cycle.
REQ-019 WRAck in READ and RDAck in WRITE SHALL be ignored.
REQ-020 A rising Interrupt edge SHALL set the matching IntPending bit; IntClear SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-021 Interrupts SHALL never stall or abort a transaction.
REQ-022 RESP SHALL last one cycle then go to IDLE, so consecutive commands are separated by at least one idle cycle.

Reset
REQ-023 nReset low SHALL asynchronously force IDLE: CmdReady=1; WE, RD, WDataReq, RspValid, RspLast, RspErr=0; Addr, DataOut, RspData, IntPending=0.
REQ-024 Reset mid-transaction SHALL discard the transaction with no response; the first command after release SHALL be accepted normally.

Configuration
REQ-025 With VPROC_TIMEOUT_EN defined, a counter SHALL restart at each beat start; TIMEOUT cycles without the awaited ack SHALL drop WE/RD and pulse RspValid with RspErr=1, RspLast=1.
REQ-026 Without VPROC_TIMEOUT_EN, the block SHALL wait indefinitely for acks, and RspErr SHALL assert only for CmdOp=11.

Verification
REQ-027 Tick: CmdOp=00, CmdTicks=5 -> one RspValid, RspLast=1, in the cycle after edge k+5; CmdTicks=0 -> after edge k+1.
REQ-028 Write burst: Addr=0x100, CmdLen=3, WRAck every cycle -> Addr 0x100/104/108/10C, three WDataReq pulses, one final RspValid.
REQ-029 Read burst: Addr=0xFFFFFFFC, CmdLen=1, RDAck with DataIn=0xA5, then 0x5A -> Addr wraps to 0x0; two RspValid with RspLast on 0x5A.
REQ-030 Timeout (VPROC_TIMEOUT_EN): read with no RDAck -> RD drops after 256 cycles; RspErr=1.
REQ-031 Interrupt: Interrupt[1] rises in the same cycle IntClear[1]=1 -> IntPending=3'b010; a later IntClear[1] alone -> 0.
REQ-032 Reset: nReset low during beat 2 of a 4-beat write -> WE=0 immediately, no RspValid, CmdReady=1.
